// File: rtl/redmule_job_sched_if.sv
// Bundle between the cluster cores / accelerator environment (master) and the
// RedMulE job scheduler (slave): request handshake, completion events, accelerator control.
interface redmule_job_sched_if #(
  parameter int N_REQ = 4,
  parameter int CFG_W = 32
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][CFG_W-1:0] req_cfg;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            done_evt;
  logic                        acc_clk_en;
  logic                        acc_start;
  logic [CFG_W-1:0]            acc_cfg;
  logic                        acc_done;
  logic [IDX_W-1:0]            owner;
  logic                        busy;
  logic                        err;

  modport master (
    output req_valid, req_cfg, acc_done,
    input  req_ready, done_evt, acc_clk_en, acc_start, acc_cfg, owner, busy, err
  );

  modport slave (
    input  req_valid, req_cfg, acc_done,
    output req_ready, done_evt, acc_clk_en, acc_start, acc_cfg, owner, busy, err
  );
endinterface

// File: rtl/redmule_job_sched.sv
// Round-robin job scheduler sharing one clock-gated RedMulE among N_REQ cores:
// grants a job, wakes the accelerator clock, pulses start, and routes completion back.
module redmule_job_sched #(
  parameter int N_REQ       = 4,
  parameter int CFG_W       = 32,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  redmule_job_sched_if.slave bus
);
  localparam int IDX_W  = $clog2(N_REQ);
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    ISSUE,
    RUN,
    COMPLETE
  } state_e;

  state_e             state_q, state_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               clk_en_q, clk_en_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic               err_q, err_d;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic               found_hi;
  logic [IDX_W-1:0]   idx_hi;
  logic [IDX_W-1:0]   idx_any;

  // Round-robin: lowest requester above last_owner wins, else wrap to the lowest overall.
  // Descending scan so the final assignment is the lowest matching index.
  always_comb begin
    gnt_found = 1'b0;
    found_hi  = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_found = 1'b1;
        idx_any   = IDX_W'(i);
        if (IDX_W'(i) > last_owner_q) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_any;
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    wake_cnt_d   = wake_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    clk_en_d     = clk_en_q;
    cfg_d        = cfg_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    err_d        = err_q | (bus.acc_done && (state_q != RUN));

    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          cfg_d        = bus.req_cfg[gnt_idx];
          owner_d      = gnt_idx;
          last_owner_d = gnt_idx;
          clk_en_d     = 1'b1;
          wake_cnt_d   = WAKE_W'(WAKE_CYCLES - 1);
          state_d      = clk_en_q ? ISSUE : WAKE;
        end else if (clk_en_q) begin
          if (idle_cnt_q == '0) clk_en_d = 1'b0;
          else                  idle_cnt_d = idle_cnt_q - IDLE_W'(1);
        end
      end
      WAKE: begin
        if (wake_cnt_q == '0) state_d = ISSUE;
        else                  wake_cnt_d = wake_cnt_q - WAKE_W'(1);
      end
      ISSUE: state_d = RUN;
      RUN: begin
        if (bus.acc_done) state_d = COMPLETE;
      end
      COMPLETE: begin
        state_d    = IDLE;
        idle_cnt_d = IDLE_W'(IDLE_CYCLES);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wake_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      clk_en_q     <= 1'b0;
      cfg_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      clk_en_q     <= clk_en_d;
      cfg_q        <= cfg_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.done_evt  = '0;
    if (state_q == IDLE && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
    if (state_q == COMPLETE)          bus.done_evt[owner_q]  = 1'b1;
  end

  assign bus.acc_clk_en = clk_en_q;
  assign bus.acc_start  = (state_q == ISSUE);
  assign bus.acc_cfg    = cfg_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_redmule_job_sched.sv
// Bench for redmule_job_sched: arbitration table, directed timing sequences,
// and a randomized run against an event-time model of the scheduling rules.
module tb_redmule_job_sched;
  localparam int N_REQ       = 4;
  localparam int CFG_W       = 32;
  localparam int WAKE_CYCLES = 2;
  localparam int IDLE_CYCLES = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  redmule_job_sched_if #(.N_REQ(N_REQ), .CFG_W(CFG_W)) bus ();

  redmule_job_sched #(
    .N_REQ      (N_REQ),
    .CFG_W      (CFG_W),
    .WAKE_CYCLES(WAKE_CYCLES),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns 1 time unit after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the bench 1 unit into cycle 0: reset just released, DUT in IDLE.
  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_cfg   = '0;
    bus.acc_done  = 1'b0;
    #1 rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // One complete job for requester idx, checked against the fixed latency rules.
  task automatic job(input int idx, input logic [CFG_W-1:0] cfg, input bit clk_on,
                     input int run_len);
    bus.req_valid      = '0;
    bus.req_valid[idx] = 1'b1;
    bus.req_cfg[idx]   = cfg;
    #1 check("job_ready", bus.req_ready, 64'(1) << idx);
    tick();
    bus.req_valid = '0;
    repeat ((clk_on ? 1 : WAKE_CYCLES + 1) - 1) tick();
    #1;
    check("job_start", bus.acc_start, 1);
    check("job_cfg", bus.acc_cfg, cfg);
    repeat (run_len) tick();
    bus.acc_done = 1'b1;
    tick();
    bus.acc_done = 1'b0;
    #1 check("job_evt", bus.done_evt, 64'(1) << idx);
    tick();
  endtask

  typedef struct {
    int               prime;
    logic [N_REQ-1:0] valid;
    logic [N_REQ-1:0] exp_ready;
    int               exp_owner;
  } arb_vec_t;

  arb_vec_t vecs[8];

  // Randomized-phase model state: event times rather than FSM states.
  int               m_free, m_start, m_evt, m_done_at, m_idle_since, m_last, m_owner;
  bit               m_en;
  logic [CFG_W-1:0] m_cfg;
  logic [N_REQ-1:0] pending;
  logic [CFG_W-1:0] pcfg[N_REQ];
  int               win, cand, rate;
  bit               idle;

  initial begin
    vecs[0] = '{-1, 4'b0000, 4'b0000, 0};
    vecs[1] = '{-1, 4'b0100, 4'b0100, 2};
    vecs[2] = '{-1, 4'b1111, 4'b0001, 0};
    vecs[3] = '{ 0, 4'b1111, 4'b0010, 1};
    vecs[4] = '{ 1, 4'b0011, 4'b0001, 0};
    vecs[5] = '{ 2, 4'b1001, 4'b1000, 3};
    vecs[6] = '{ 3, 4'b1110, 4'b0010, 1};
    vecs[7] = '{ 2, 4'b0100, 4'b0100, 2};

    bus.req_valid = '0;
    bus.req_cfg   = '0;
    bus.acc_done  = 1'b0;

    // Reset values and single-job timing from a gated clock.
    do_reset();
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_evt", bus.done_evt, 0);
    check("rst_clk_en", bus.acc_clk_en, 0);
    check("rst_start", bus.acc_start, 0);
    check("rst_cfg", bus.acc_cfg, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    bus.req_cfg[2]  = 32'h1000;
    bus.req_valid   = 4'b0100;
    #1;
    check("a_ready0", bus.req_ready, 4'b0100);
    check("a_clk_en0", bus.acc_clk_en, 0);
    tick();
    bus.req_valid = '0;
    #1;
    check("a_clk_en1", bus.acc_clk_en, 1);
    check("a_ready1", bus.req_ready, 0);
    check("a_start1", bus.acc_start, 0);
    tick();
    #1 check("a_start2", bus.acc_start, 0);
    tick();
    #1;
    check("a_start3", bus.acc_start, 1);
    check("a_cfg3", bus.acc_cfg, 32'h1000);
    check("a_owner3", bus.owner, 2);
    repeat (7) tick();
    bus.acc_done = 1'b1;
    #1 check("a_evt10", bus.done_evt, 0);
    tick();
    bus.acc_done = 1'b0;
    #1;
    check("a_evt11", bus.done_evt, 4'b0100);
    check("a_busy11", bus.busy, 1);
    tick();
    #1;
    check("a_busy12", bus.busy, 0);
    check("a_err12", bus.err, 0);

    // Idle hysteresis: enable on for IDLE_CYCLES+1 idle cycles, then off.
    for (int k = 0; k < IDLE_CYCLES + 2; k++) begin
      check("h_clk_en", bus.acc_clk_en, (k <= IDLE_CYCLES) ? 1 : 0);
      tick();
      #1;
    end
    job(1, 32'h2000, 1'b0, 3);
    repeat (3) tick();
    #1 check("h_clk_en_kept", bus.acc_clk_en, 1);
    job(3, 32'h3000, 1'b1, 2);

    // Arbitration table, each vector from a fresh reset and optional priming job.
    foreach (vecs[v]) begin
      do_reset();
      if (vecs[v].prime >= 0) job(vecs[v].prime, 32'hA000 + vecs[v].prime, 1'b0, 2);
      for (int r = 0; r < N_REQ; r++) bus.req_cfg[r] = 32'hB000 + r;
      bus.req_valid = vecs[v].valid;
      #1 check("arb_ready", bus.req_ready, vecs[v].exp_ready);
      tick();
      bus.req_valid = '0;
      #1;
      check("arb_busy", bus.busy, (vecs[v].exp_ready != '0) ? 1 : 0);
      if (vecs[v].exp_ready != '0) begin
        check("arb_owner", bus.owner, vecs[v].exp_owner);
        check("arb_cfg", bus.acc_cfg, 32'hB000 + vecs[v].exp_owner);
      end
    end

    // Spurious done in ISSUE: flags err, job still finishes on the RUN done.
    do_reset();
    bus.req_cfg[0] = 32'h4000;
    bus.req_valid  = 4'b0001;
    tick();
    bus.req_valid = '0;
    repeat (2) tick();
    bus.acc_done = 1'b1;
    #1 check("s_start", bus.acc_start, 1);
    tick();
    bus.acc_done = 1'b0;
    #1;
    check("s_busy_run", bus.busy, 1);
    check("s_no_evt", bus.done_evt, 0);
    check("s_err_issue", bus.err, 1);
    repeat (2) tick();
    bus.acc_done = 1'b1;
    tick();
    bus.acc_done = 1'b0;
    #1 check("s_evt", bus.done_evt, 4'b0001);
    tick();
    #1;
    check("s_idle", bus.busy, 0);
    check("s_err_sticky", bus.err, 1);

    // Spurious done in IDLE.
    do_reset();
    #1 check("s2_err_clear", bus.err, 0);
    bus.acc_done = 1'b1;
    tick();
    bus.acc_done = 1'b0;
    #1;
    check("s2_err_idle", bus.err, 1);
    check("s2_no_evt", bus.done_evt, 0);
    check("s2_busy", bus.busy, 0);
    repeat (3) tick();
    #1 check("s2_err_hold", bus.err, 1);

    // Asynchronous reset in RUN, then requester 0 wins first.
    do_reset();
    bus.req_cfg[1] = 32'h55;
    bus.req_valid  = 4'b0010;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    #1 check("r_busy_run", bus.busy, 1);
    rst_ni = 1'b0;
    #1;
    check("r_ready", bus.req_ready, 0);
    check("r_evt", bus.done_evt, 0);
    check("r_clk_en", bus.acc_clk_en, 0);
    check("r_start", bus.acc_start, 0);
    check("r_cfg", bus.acc_cfg, 0);
    check("r_owner", bus.owner, 0);
    check("r_busy", bus.busy, 0);
    check("r_err", bus.err, 0);
    tick();
    rst_ni = 1'b1;
    bus.req_valid = 4'b1001;
    #1 check("r_first", bus.req_ready, 4'b0001);

    // Randomized traffic against the event-time model.
    do_reset();
    m_free    = 0;       m_start = -1;       m_evt   = -1;
    m_done_at = -1;      m_idle_since = 0;   m_last  = N_REQ - 1;
    m_owner   = 0;       m_en    = 1'b0;     m_cfg   = '0;
    pending   = '0;
    for (int r = 0; r < N_REQ; r++) pcfg[r] = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rate = ((cyc / 300) % 2 == 0) ? 3 : 40;
      for (int r = 0; r < N_REQ; r++) begin
        if (!pending[r] && $urandom_range(0, rate) == 0) begin
          pending[r] = 1'b1;
          pcfg[r]    = $urandom;
        end
        bus.req_cfg[r] = pcfg[r];
      end
      bus.req_valid = pending;
      bus.acc_done  = (cyc == m_done_at);
      #1;
      idle = (cyc >= m_free);
      win  = -1;
      if (idle) begin
        for (int i = 1; i <= N_REQ; i++) begin
          cand = (m_last + i) % N_REQ;
          if (win < 0 && pending[cand]) win = cand;
        end
      end
      check("rnd_ready", bus.req_ready, (win >= 0) ? (64'(1) << win) : 64'(0));
      check("rnd_start", bus.acc_start, (cyc == m_start) ? 1 : 0);
      check("rnd_evt", bus.done_evt, (cyc == m_evt) ? (64'(1) << m_owner) : 64'(0));
      check("rnd_busy", bus.busy, idle ? 0 : 1);
      check("rnd_clk_en", bus.acc_clk_en, m_en);
      check("rnd_cfg", bus.acc_cfg, m_cfg);
      check("rnd_owner", bus.owner, m_owner);
      check("rnd_err", bus.err, 0);
      if (win >= 0) begin
        m_owner      = win;
        m_cfg        = pcfg[win];
        m_last       = win;
        pending[win] = 1'b0;
        m_start      = cyc + (m_en ? 1 : WAKE_CYCLES + 1);
        m_free       = 1 << 30;
        m_en         = 1'b1;
      end else if (idle && m_en && (cyc - m_idle_since >= IDLE_CYCLES)) begin
        m_en = 1'b0;
      end
      if (cyc == m_start) m_done_at = cyc + int'($urandom_range(1, 6));
      if (cyc == m_done_at) begin
        m_evt        = cyc + 1;
        m_free       = cyc + 2;
        m_idle_since = cyc + 2;
      end
      tick();
    end
    bus.req_valid = '0;
    bus.acc_done  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/redmule_job_sched.md
# redmule_job_sched

Job scheduler that shares one RedMulE accelerator instance among N_REQ requesting cores. It arbitrates job requests round-robin, drives the accelerator clock-enable with wake-up latency and idle hysteresis, issues a single-cycle start with the winning job descriptor, and returns a per-requester completion event. It sits between the cluster cores and the clock-gated accelerator top, replacing a static fetch-enable.

## Interface

Parameters:
- N_REQ, 4, number of requesters (≥2)
- CFG_W, 32, job descriptor width (pointer to job struct in TCDM)
- WAKE_CYCLES, 2, cycles between clk_en_o rising and start issue (≥1)
- IDLE_CYCLES, 8, idle cycles with clock on before clk_en_o drops (≥0)
- IDX_W, localparam, $clog2(N_REQ)

Ports:
- clk_i  in  1  clock (ungated)
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  N_REQ  job request per requester; held until accepted
- req_cfg_i  in  N_REQ×CFG_W  descriptor per requester; stable while valid
- req_ready_o  out  N_REQ  one-hot acceptance
- done_evt_o  out  N_REQ  one-cycle completion pulse to job owner
- acc_clk_en_o  out  1  accelerator clock enable
- acc_start_o  out  1  one-cycle start pulse
- acc_cfg_o  out  CFG_W  latched descriptor of current job
- acc_done_i  in  1  accelerator completion pulse
- owner_o  out  IDX_W  index of current/last owner
- busy_o  out  1  high whenever state ≠ IDLE
- err_o  out  1  sticky: acc_done_i seen outside RUN

## Operation

- States: IDLE, WAKE, ISSUE, RUN, COMPLETE.
- Arbitration (IDLE only): round-robin; search starts at (last_owner+1) mod N_REQ; last_owner resets to N_REQ-1 so requester 0 has first priority.
- IDLE, any req_valid_i: req_ready_o[winner]=1 combinationally same cycle; on clock edge latch req_cfg_i[winner] → acc_cfg_o, winner → owner_o/last_owner; acc_clk_en_o←1. Next = ISSUE if acc_clk_en_o already 1, else WAKE (wake counter ← WAKE_CYCLES-1).
- WAKE: counter decrements; at 0 → ISSUE. No grants.
- ISSUE: acc_start_o=1 for exactly this cycle → RUN.
- RUN: wait acc_done_i; on it → COMPLETE. No timeout.
- COMPLETE: done_evt_o[owner_o]=1 for this cycle → IDLE; idle counter ← IDLE_CYCLES.
- IDLE, no request, acc_clk_en_o=1: if idle counter = 0 then acc_clk_en_o←0, else decrement. IDLE_CYCLES=0 drops the enable at the end of the first IDLE cycle.
- A request in IDLE takes priority over the idle countdown (enable stays 1, no gating).
- acc_done_i in any state other than RUN: ignored for sequencing, sets err_o.
- req_ready_o is 0 in every state except IDLE; at most one bit is high.
- acc_cfg_o holds the last descriptor until the next grant.

## Timing

- Reset values: state IDLE, req_ready_o 0, done_evt_o 0, acc_clk_en_o 0, acc_start_o 0, acc_cfg_o 0, owner_o 0, busy_o 0, err_o 0, last_owner N_REQ-1.
- Grant at cycle 0, clock off: acc_clk_en_o high from cycle 1, WAKE cycles 1..WAKE_CYCLES, acc_start_o at cycle WAKE_CYCLES+1.
- Grant at cycle 0, clock on: acc_start_o at cycle 1.
- acc_done_i at cycle t (RUN): done_evt_o at t+1, IDLE at t+2, earliest next grant at t+2.
- acc_done_i coincident with acc_start_o (ISSUE): sets err_o, does not complete the job.
- Back-to-back jobs: one dead cycle between done_evt_o and next req_ready_o is not allowed; grant occurs in the first IDLE cycle (t+2).
- Reset mid-job: all outputs return to reset values asynchronously; the accelerator is reset by the same rst_ni. Pending requesters must re-assert.

## Test plan

- N_REQ=4, WAKE_CYCLES=2, IDLE_CYCLES=4; single req_valid_i[2] from reset with cfg 0x1000 → req_ready_o=4'b0100 at cycle 0, acc_clk_en_o=1 at cycle 1, acc_start_o at cycle 3, acc_cfg_o=0x1000; acc_done_i at cycle 10 → done_evt_o=4'b0100 at cycle 11, busy_o=0 at cycle 12.
- All four valid simultaneously, each job done 5 cycles after start → grant order 0,1,2,3; each done_evt_o to the matching index; only the first job pays WAKE latency.
- Requester 1 re-requests immediately after its done while 3 is waiting → 3 granted before 1.
- No requests after a job → acc_clk_en_o falls exactly 5 cycles after entering IDLE (IDLE_CYCLES=4); new request on the 4th idle cycle → enable stays 1, start one cycle after grant.
- Spurious acc_done_i in IDLE and in ISSUE → err_o=1 and stays 1; no done_evt_o; job in ISSUE still completes on the later acc_done_i in RUN.
- Assert rst_ni low during RUN → all outputs at reset values immediately; after release, req_valid_i[0] is granted first.
